// File: rtl/wfull_if.sv
// rtl/wfull_if.sv - write-side pointer/full-flag bundle for the async FIFO write domain
interface wfull_if #(
  parameter int AW = 4
);
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wovf;
  logic          walmost_full;

  // Producer / read-domain side: drives requests and the read pointer, observes status
  modport master (
    output winc,
    output wq2_rptr,
    input  waddr,
    input  wptr,
    input  wfull,
    input  wovf,
    input  walmost_full
  );

  // Pointer generator side
  modport slave (
    input  winc,
    input  wq2_rptr,
    output waddr,
    output wptr,
    output wfull,
    output wovf,
    output walmost_full
  );
endinterface

// File: rtl/wfull.sv
// rtl/wfull.sv - async FIFO write pointer, full/overflow flags; optional almost-full under WFULL_ALMOST_FULL_EN
module wfull #(
  parameter int DEPTH           = 16,
  parameter int FIFO_ADDR_WIDTH = $clog2(DEPTH),
  parameter int AFULL_MARGIN    = 2
) (
  input  logic          wclk,
  input  logic          reset,
  wfull_if.slave        bus
);
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  // Parameter sanity: power-of-two depth of at least 4, margin inside 1..DEPTH-1
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("wfull: DEPTH must be a power of two >= 4 matching FIFO_ADDR_WIDTH");
  end
  if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
    $error("wfull: AFULL_MARGIN must lie in 1..DEPTH-1");
  end

  logic [AW:0] r_wbin;
  logic [AW:0] r_s0;
  logic [AW:0] r_s1;
  logic        r_ovf;

  logic [AW:0] w_wptr;
  logic [AW:0] w_full_ref;
  logic        w_wfull;
  logic        w_accept;
  logic        w_reject;
  logic        w_afull;

  // Gray pointer straight off the binary register: only one bit moves per increment
  assign w_wptr = (r_wbin >> 1) ^ r_wbin;

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer
  assign w_full_ref = {~r_s1[AW:AW-1], r_s1[AW-2:0]};
  assign w_wfull    = (w_wptr == w_full_ref);

  assign w_accept = bus.winc && !w_wfull;
  assign w_reject = bus.winc &&  w_wfull;

  // Write-domain state: pointer advance, two-flop read-pointer synchroniser, sticky overflow
  always_ff @(negedge wclk) begin
    if (!reset) begin
      r_wbin <= '0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_s0 <= bus.wq2_rptr;
      r_s1 <= r_s0;
      if (w_accept) begin
        r_wbin <= r_wbin + ONE;
      end
      if (w_reject) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef WFULL_ALMOST_FULL_EN
  localparam logic [AW:0] AFULL_THRESH = (AW + 1)'(DEPTH - AFULL_MARGIN);

  logic [AW:0] w_rbin;
  logic [AW:0] w_level;

  // Gray-to-binary of the synchronised read pointer (prefix XOR from the MSB down)
  always_comb begin
    w_rbin     = '0;
    w_rbin[AW] = r_s1[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      w_rbin[i] = w_rbin[i + 1] ^ r_s1[i];
    end
  end

  // Occupancy as seen from the write side; stale rs only ever overstates it
  assign w_level = r_wbin - w_rbin;
  assign w_afull = (w_level >= AFULL_THRESH) || w_wfull;
`else
  assign w_afull = 1'b0;
`endif

  assign bus.waddr        = r_wbin[AW-1:0];
  assign bus.wptr         = w_wptr;
  assign bus.wfull        = w_wfull;
  assign bus.wovf         = r_ovf;
  assign bus.walmost_full = w_afull;
endmodule

// File: tb/tb_wfull.sv
// tb/tb_wfull.sv - directed self-checking bench for wfull
module tb_wfull;
  localparam int AW = 4;

  logic wclk;
  logic reset;
  int   n_vec;
  int   n_fail;
  logic [AW:0] m_wbin;
  logic        exp_af;

  wfull_if #(.AW(AW)) bus ();

  wfull #(.DEPTH(16), .FIFO_ADDR_WIDTH(AW), .AFULL_MARGIN(2)) dut (
    .wclk  (wclk),
    .reset (reset),
    .bus   (bus)
  );

  initial wclk = 1'b1;
  always #5 wclk = ~wclk;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic af_exp(input logic cond);
`ifdef WFULL_ALMOST_FULL_EN
    return cond;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(negedge wclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_waddr"}, 8'(bus.waddr), 8'h00);
    check({tag, "_wptr"},  8'(bus.wptr),  8'h00);
    check({tag, "_wfull"}, 8'(bus.wfull), 8'h00);
    check({tag, "_wovf"},  8'(bus.wovf),  8'h00);
    check({tag, "_afull"}, 8'(bus.walmost_full), 8'h00);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.winc     = 1'b1;
    bus.wq2_rptr = '0;

    // Reset held two edges with winc asserted
    tick();
    tick();
    check_reset_outputs("reset");

    // Fill 16 entries with the read pointer at 0
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("fill%0d_waddr", i), 8'(bus.waddr), 8'(i % 16));
      check($sformatf("fill%0d_wfull", i), 8'(bus.wfull), 8'(i == 16));
      check($sformatf("fill%0d_afull", i), 8'(bus.walmost_full), 8'(af_exp(i >= 14)));
    end
    check("fill_wptr", 8'(bus.wptr), 8'b11000);
    check("fill_wovf", 8'(bus.wovf), 8'h00);

    // Overflow: three rejected writes
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ovf%0d_waddr", i), 8'(bus.waddr), 8'h00);
      check($sformatf("ovf%0d_wptr", i),  8'(bus.wptr),  8'b11000);
      check($sformatf("ovf%0d_wovf", i),  8'(bus.wovf),  8'h01);
    end
    bus.winc = 1'b0;
    tick();
    check("ovf_sticky", 8'(bus.wovf), 8'h01);
    check("ovf_full",   8'(bus.wfull), 8'h01);

    // Drain visibility: read pointer advances to 1
    bus.wq2_rptr = 5'b00001;
    tick();
    check("drain1_wfull", 8'(bus.wfull), 8'h01);
    check("drain1_afull", 8'(bus.walmost_full), 8'(af_exp(1'b1)));
    tick();
    check("drain2_wfull", 8'(bus.wfull), 8'h00);
    check("drain2_afull", 8'(bus.walmost_full), 8'(af_exp(1'b1)));
    bus.winc = 1'b1;
    tick();
    check("drain_wptr",  8'(bus.wptr),  8'b11001);
    check("drain_waddr", 8'(bus.waddr), 8'h01);
    check("drain_refull", 8'(bus.wfull), 8'h01);
    bus.winc = 1'b0;

    // Fresh start for the wrap walk
    reset = 1'b0;
    bus.wq2_rptr = '0;
    tick();
    tick();
    check_reset_outputs("rst2");
    reset = 1'b1;

    // Wrap: 40 writes, read pointer trailing closely
    m_wbin = '0;
    for (int k = 1; k <= 40; k++) begin
      bus.wq2_rptr = gray(m_wbin);
      bus.winc     = 1'b1;
      tick();
      m_wbin = m_wbin + 5'd1;
      check($sformatf("wrap%0d_wptr", k),  8'(bus.wptr),  8'(gray(m_wbin)));
      check($sformatf("wrap%0d_wfull", k), 8'(bus.wfull), 8'h00);
      check($sformatf("wrap%0d_wovf", k),  8'(bus.wovf),  8'h00);
      check($sformatf("wrap%0d_afull", k), 8'(bus.walmost_full), 8'h00);
      if (k == 31) check("wrap_g31", 8'(bus.wptr), 8'b10000);
      if (k == 32) check("wrap_g0",  8'(bus.wptr), 8'b00000);
    end
    check("wrap_end_wptr",  8'(bus.wptr),  8'b01100);
    check("wrap_end_waddr", 8'(bus.waddr), 8'h08);
    bus.winc = 1'b0;

    // Mid-run reset after 5 writes
    reset = 1'b0;
    bus.wq2_rptr = '0;
    tick();
    tick();
    reset = 1'b1;
    bus.winc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_pre_waddr", 8'(bus.waddr), 8'h05);
    check("mid_pre_wptr",  8'(bus.wptr),  8'b00111);
    reset = 1'b0;
    tick();
    check_reset_outputs("mid");
    reset = 1'b1;
    tick();
    check("mid_post_waddr", 8'(bus.waddr), 8'h01);
    check("mid_post_wptr",  8'(bus.wptr),  8'b00001);
    bus.winc = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/wfull.md
# wfull

Write-side pointer and full-flag generator for the interface-unit asynchronous FIFO. It is the upstream neighbour of the read-empty logic: it advances the binary write address on accepted writes and publishes a Gray-coded write pointer that the read domain synchronises. It also synchronises the read domain's Gray pointer into the write domain and derives the full flag, a sticky overflow error and, optionally, an almost-full flag.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 4.
- FIFO_ADDR_WIDTH, $clog2(DEPTH), address width (AW below).
- AFULL_MARGIN, 2, almost-full asserts when free entries ≤ AFULL_MARGIN; range 1..DEPTH-1.

Ports:
- wclk  in  1  write-domain clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-low reset, sampled on the falling edge of wclk.
- winc  in  1  write request from the producer.
- wq2_rptr  in  AW+1  Gray-coded read pointer from the read domain (asynchronous to wclk).
- waddr  out  AW  binary write address to the FIFO memory.
- wptr  out  AW+1  Gray-coded write pointer to the read domain.
- wfull  out  1  FIFO full.
- wovf  out  1  sticky overflow error.
- walmost_full  out  1  almost-full flag; 0 when WFULL_ALMOST_FULL_EN is undefined.

## Operation
- State: binary counter wbin[AW:0]; synchroniser flops s0, s1 [AW:0]; overflow register ovf.
- Write accept: winc && !wfull → wbin <= wbin + 1 (modulo 2^(AW+1), natural wrap).
- Rejected write: winc && wfull → wbin unchanged; ovf <= 1 and holds until reset.
- Synchroniser: s0 <= wq2_rptr; s1 <= s0. Synchronised read pointer rs = s1.
- wptr = (wbin >> 1) ^ wbin (combinational from the register, glitch-free per step).
- waddr = wbin[AW-1:0].
- wfull = (wptr == {~rs[AW:AW-1], rs[AW-2:0]}), combinational from registered state.
- wovf = ovf.
- Almost-full (when enabled): rbin = Gray-to-binary(rs); level = (wbin - rbin) mod 2^(AW+1), AW+1 bits; walmost_full = (level ≥ DEPTH - AFULL_MARGIN). walmost_full is 1 whenever wfull is 1.
- Reset (reset == 0 on a falling edge): wbin, s0, s1 and ovf are cleared; winc is ignored on that edge. This applies mid-operation with no exception.

## Timing
- Reset values: waddr = 0, wptr = 0, wfull = 0, wovf = 0, walmost_full = 0.
- The write takes effect on the falling edge where winc && !wfull holds. waddr and wptr update on that same edge. wfull and walmost_full reflect the new count immediately after the edge.
- Read-pointer latency: a change on wq2_rptr is seen in rs after 2 falling edges. Full and almost-full deassert no sooner than that (pessimistic, never optimistic).
- Simultaneous write and read-pointer advance: the write is judged against the current rs; the freed entry becomes visible 2 edges later.
- Wrap-around: wbin steps from 2^(AW+1)-1 to 0. wptr then steps from Gray 10…0 to 0…0, a single-bit change.

## Configuration
- WFULL_ALMOST_FULL_EN defined: the Gray-to-binary converter, level subtractor and comparator are built, and walmost_full behaves as specified.
- WFULL_ALMOST_FULL_EN undefined: none of that logic exists, walmost_full is tied to 0, and all other behaviour is identical.

## Test plan
- Reset: drive reset=0 for 2 edges with winc=1 → waddr=0, wptr=5'b00000, wfull=0, wovf=0, walmost_full=0.
- Fill: wq2_rptr=0 and 16 consecutive winc → after the 16th edge, wbin=16, wptr=5'b11000 and wfull=1. With the macro enabled, walmost_full=1 after the 14th write.
- Overflow: while full, pulse winc for 3 edges → waddr stays 0, wptr stays 5'b11000, wovf=1 and stays 1 after winc drops.
- Drain visibility: while full, set wq2_rptr=5'b00001 (read pointer 1) → wfull still 1 after 1 edge, 0 after 2 edges. The next winc is accepted, giving wptr=Gray(17)=5'b11001.
- Wrap: interleave writes with read-pointer updates kept ≤ 16 behind for 40 writes → wptr walks Gray(31)=5'b10000 → 5'b00000 → … → Gray(8)=5'b01100. wfull and wovf are never asserted.
- Mid-run reset: after 5 writes, assert reset=0 for 1 edge while winc=1 → all outputs return to their reset values, and the following write produces waddr=1.
